screen_sequencer: RTL

SCREEN_SEQUENCER -- requirements
Module: screen_sequencer

---
 rtl/screen_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/screen_sequencer.sv
// Frame-synchronous screen/game sequencer: start, play, dying pause, game over, win.
// All state and screen outputs change only on the frame_tick cycle (first vblank pixel).
//
// state | meaning
// START | title screen, waiting for a jump press
// PLAY  | game running, physics and scrolling enabled
// DYING | death pause, physics frozen for DEATH_FRAMES frames
// OVER  | game-over screen, waiting for a press
// WIN   | level-complete screen, waiting for a press
module screen_sequencer #(
   parameter int SCREEN_HEIGHT = 480,
   parameter int DEATH_FRAMES  = 120,
   parameter int START_LIVES   = 3
) (
   input  logic       vga_clock,
   input  logic       reset,
   input  logic       jump_button,
   input  logic       mario_dead,
   input  logic       level_done,
   input  int         row,
   input  int         column,
   output logic [1:0] screen_select,
   output logic       game_run,
   output logic       game_reset,
   output logic [1:0] lives,
   output logic       frame_tick
);

   localparam int CNT_W = (DEATH_FRAMES > 256) ? $clog2(DEATH_FRAMES) : 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEATH_FRAMES - 1);

   typedef enum logic [2:0] {
      ST_START = 3'd0,
      ST_PLAY  = 3'd1,
      ST_DYING = 3'd2,
      ST_OVER  = 3'd3,
      ST_WIN   = 3'd4
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       lives_q;
   logic [1:0]       select_q;
   logic             run_q;
   logic             game_reset_q;
   logic             sync1_q;
   logic             sync2_q;
   logic             sample_q;
   logic             armed_q;
   logic             press;

   assign frame_tick = (row == SCREEN_HEIGHT) && (column == 0);

   // armed_q blocks a button that was already held through reset until a released frame is seen
   assign press = frame_tick && sync2_q && !sample_q && armed_q;

   always_ff @(posedge vga_clock) begin
      if (reset) begin
         state_q      <= ST_START;
         cnt_q        <= '0;
         lives_q      <= 2'd0;
         select_q     <= 2'd0;
         run_q        <= 1'b0;
         game_reset_q <= 1'b0;
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         sample_q     <= 1'b0;
         armed_q      <= 1'b0;
      end else begin
         sync1_q      <= jump_button;
         sync2_q      <= sync1_q;
         game_reset_q <= 1'b0;
         if (frame_tick) begin
            sample_q <= sync2_q;
            if (!sync2_q) armed_q <= 1'b1;
            case (state_q)
               ST_START: begin
                  if (press) begin
                     state_q      <= ST_PLAY;
                     lives_q      <= 2'(START_LIVES);
                     game_reset_q <= 1'b1;
                     select_q     <= 2'd1;
                     run_q        <= 1'b1;
                  end
               end
               ST_PLAY: begin
                  if (level_done) begin
                     state_q  <= ST_WIN;
                     select_q <= 2'd3;
                     run_q    <= 1'b0;
                  end else if (mario_dead) begin
                     state_q  <= ST_DYING;
                     cnt_q    <= '0;
                     lives_q  <= (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
                     select_q <= 2'd1;
                     run_q    <= 1'b0;
                  end
               end
               ST_DYING: begin
                  if (cnt_q == CNT_LAST) begin
                     if (lives_q == 2'd0) begin
                        state_q  <= ST_OVER;
                        select_q <= 2'd2;
                        run_q    <= 1'b0;
                     end else begin
                        state_q      <= ST_PLAY;
                        game_reset_q <= 1'b1;
                        select_q     <= 2'd1;
                        run_q        <= 1'b1;
                     end
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               ST_OVER, ST_WIN: begin
                  if (press) begin
                     state_q  <= ST_START;
                     select_q <= 2'd0;
                     run_q    <= 1'b0;
                  end
               end
               default: begin
                  state_q  <= ST_START;
                  select_q <= 2'd0;
                  run_q    <= 1'b0;
               end
            endcase
         end
      end
   end

   assign screen_select = select_q;
   assign game_run      = run_q;
   assign game_reset    = game_reset_q;
   assign lives         = lives_q;

endmodule
